// File: rtl/qnet_tx_arbiter.sv
// Round-robin arbiter that shares the link TX command port between the local
// command processor (LOC) and the forwarding path (FWD), with timeout and transfer count.
module qnet_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             t_clk_i,
  input  logic             t_rst_ni,
  input  logic             link_rdy_i,
  input  logic             loc_req_i,
  input  logic [63:0]      loc_header_i,
  input  logic [63:0]      loc_data_i,
  output logic             loc_ack_o,
  input  logic             fwd_req_i,
  input  logic [63:0]      fwd_header_i,
  input  logic [63:0]      fwd_data_i,
  output logic             fwd_ack_o,
  output logic             tx_req_o,
  output logic [63:0]      tx_header_o,
  output logic [63:0]      tx_data_o,
  input  logic             tx_ack_i,
  output logic             err_o,
  output logic             busy_o,
  output logic [1:0]       grant_o,
  output logic [CNT_W-1:0] tx_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // A zero timeout disables the counter, but it still needs at least one bit.
  localparam int unsigned TO_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYC == 0) ? '0 : TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]      state_reg;
  logic            last_fwd_reg;
  logic [TO_W-1:0] to_cnt_reg;

  logic any_req;
  logic pick_fwd;
  logic timeout_hit;

  // last_fwd_reg holds the previous owner; on a tie the other side wins.
  assign any_req     = loc_req_i | fwd_req_i;
  assign pick_fwd    = (loc_req_i & fwd_req_i) ? ~last_fwd_reg : fwd_req_i;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt_reg == TO_LAST);

  always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
    if (!t_rst_ni) begin
      state_reg    <= ST_IDLE;
      last_fwd_reg <= 1'b1;
      to_cnt_reg   <= '0;
      loc_ack_o    <= 1'b0;
      fwd_ack_o    <= 1'b0;
      tx_req_o     <= 1'b0;
      tx_header_o  <= '0;
      tx_data_o    <= '0;
      err_o        <= 1'b0;
      busy_o       <= 1'b0;
      grant_o      <= 2'b00;
      tx_cnt_o     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (link_rdy_i && any_req) begin
            last_fwd_reg <= pick_fwd;
            tx_header_o  <= pick_fwd ? fwd_header_i : loc_header_i;
            tx_data_o    <= pick_fwd ? fwd_data_i   : loc_data_i;
            tx_req_o     <= 1'b1;
            grant_o      <= pick_fwd ? 2'b10 : 2'b01;
            busy_o       <= 1'b1;
            to_cnt_reg   <= '0;
            state_reg    <= ST_SEND;
          end
        end
        ST_SEND: begin
          // An ack arriving on the timeout cycle still counts as a clean transfer.
          if (tx_ack_i || timeout_hit) begin
            tx_req_o  <= 1'b0;
            loc_ack_o <= grant_o[0];
            fwd_ack_o <= grant_o[1];
            err_o     <= ~tx_ack_i;
            if (tx_ack_i) begin
              tx_cnt_o <= tx_cnt_o + CNT_W'(1);
            end
            state_reg <= ST_ACK;
          end else if (TIMEOUT_CYC != 0) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end
        ST_ACK: begin
          loc_ack_o  <= 1'b0;
          fwd_ack_o  <= 1'b0;
          err_o      <= 1'b0;
          grant_o    <= 2'b00;
          busy_o     <= 1'b0;
          to_cnt_reg <= '0;
          state_reg  <= ST_IDLE;
        end
        default: begin
          tx_req_o  <= 1'b0;
          loc_ack_o <= 1'b0;
          fwd_ack_o <= 1'b0;
          err_o     <= 1'b0;
          grant_o   <= 2'b00;
          busy_o    <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
